// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle for alu_seq
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             sign;
  logic             div_zero;

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result, result_hi, carry, overflow, zero, sign, div_zero
  );

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result, result_hi, carry, overflow, zero, sign, div_zero
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with shift-add MUL and restoring DIV
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                         OP_XOR = 4'h4, OP_NOT = 4'h5, OP_LSH = 4'h6, OP_RSH = 4'h7,
                         OP_LT  = 4'h8, OP_GT  = 4'h9, OP_EQ  = 4'hA, OP_INC = 4'hB,
                         OP_DEC = 4'hC, OP_MUL = 4'hD, OP_DIV = 4'hE;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] wrk_hi, wrk_lo;

  logic [WIDTH-1:0] res_q, hi_q;
  logic             carry_q, ovf_q, zero_q, sign_q, dz_q;

  logic             accept;
  assign accept = (state == S_IDLE) && bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (bus.opcode == OP_MUL)                         state_nxt = S_MUL;
          else if (bus.opcode == OP_DIV && bus.b != '0)     state_nxt = S_DIV;
          else                                              state_nxt = S_DONE;
        end
      end
      S_MUL, S_DIV: if (cnt == '0) state_nxt = S_DONE;
      S_DONE:       if (bus.out_ready) state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle results, computed straight from the live inputs at accept
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] s_res, s_hi;
  logic             s_c, s_v, s_dz;

  assign add_w = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_w = {1'b0, bus.a} - {1'b0, bus.b};

  always_comb begin
    s_res = '0;
    s_hi  = '0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    s_dz  = 1'b0;
    case (bus.opcode)
      OP_ADD: begin
        s_res = add_w[WIDTH-1:0];
        s_c   = add_w[WIDTH];
        s_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        s_res = sub_w[WIDTH-1:0];
        s_c   = sub_w[WIDTH];
        s_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: s_res = bus.a & bus.b;
      OP_OR:  s_res = bus.a | bus.b;
      OP_XOR: s_res = bus.a ^ bus.b;
      OP_NOT: s_res = ~bus.a;
      OP_LSH: begin
        s_res = {bus.a[WIDTH-2:0], 1'b0};
        s_c   = bus.a[WIDTH-1];
      end
      OP_RSH: begin
        s_res = {1'b0, bus.a[WIDTH-1:1]};
        s_c   = bus.a[0];
      end
      OP_LT:  s_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_GT:  s_res = {{(WIDTH-1){1'b0}}, (bus.a > bus.b)};
      OP_EQ:  s_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
      OP_INC: begin
        s_res = bus.a + WIDTH'(1);
        s_c   = &bus.a;
      end
      OP_DEC: begin
        s_res = bus.a - WIDTH'(1);
        s_c   = ~|bus.a;
      end
      // Only reaches the output load when b == 0; b != 0 goes iterative
      OP_DIV: begin
        s_res = '1;
        s_hi  = bus.a;
        s_c   = 1'b1;
        s_dz  = 1'b1;
      end
      default: ;
    endcase
  end

  // One iteration step; {wrk_hi, wrk_lo} is product-so-far / {remainder, dividend-shifting}
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] fin_hi, fin_lo;

  assign mul_sum  = {1'b0, wrk_hi} + (wrk_lo[0] ? {1'b0, opb} : '0);
  assign div_sh   = {wrk_hi, wrk_lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opb};
  assign div_ok   = ~div_diff[WIDTH];

  always_comb begin
    if (state == S_MUL) begin
      fin_hi = mul_sum[WIDTH:1];
      fin_lo = {mul_sum[0], wrk_lo[WIDTH-1:1]};
    end else begin
      fin_hi = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      fin_lo = {wrk_lo[WIDTH-2:0], div_ok};
    end
  end

  logic             ld_en, last_iter;
  logic [WIDTH-1:0] ld_res, ld_hi;
  logic             ld_c, ld_v, ld_dz;

  assign last_iter = (state == S_MUL || state == S_DIV) && (cnt == '0);
  assign ld_en     = (accept && state_nxt == S_DONE) || last_iter;

  always_comb begin
    if (state == S_IDLE) begin
      ld_res = s_res;
      ld_hi  = s_hi;
      ld_c   = s_c;
      ld_v   = s_v;
      ld_dz  = s_dz;
    end else begin
      ld_res = fin_lo;
      ld_hi  = fin_hi;
      ld_c   = (state == S_MUL) && (fin_hi != '0);
      ld_v   = (state == S_MUL) && (fin_hi != '0);
      ld_dz  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      opb     <= '0;
      wrk_hi  <= '0;
      wrk_lo  <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      sign_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      if (accept) begin
        opb    <= bus.b;
        wrk_hi <= '0;
        wrk_lo <= bus.a;
        cnt    <= CW'(WIDTH - 1);
      end else if (state == S_MUL || state == S_DIV) begin
        wrk_hi <= fin_hi;
        wrk_lo <= fin_lo;
        cnt    <= cnt - 1'b1;
      end
      if (ld_en) begin
        res_q   <= ld_res;
        hi_q    <= ld_hi;
        carry_q <= ld_c;
        ovf_q   <= ld_v;
        zero_q  <= (ld_res == '0);
        sign_q  <= ld_res[WIDTH-1];
        dz_q    <= ld_dz;
      end
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = res_q;
  assign bus.result_hi = hi_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.sign      = sign_q;
  assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq at WIDTH=16
module tb_alu_seq;
  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, res, hi;
    logic         c, v, z, s, dz;
    int           lat;
    int           acc;
  } vec_t;

  vec_t sbq[$];
  vec_t tbl[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, b, res, hi,
                              input logic c, v, z, s, dz, input int lat);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.res = res; t.hi = hi;
    t.c = c; t.v = v; t.z = z; t.s = s; t.dz = dz;
    t.lat = lat; t.acc = 0;
    return t;
  endfunction

  task automatic issue(input vec_t v);
    int n;
    @(negedge clk);
    bus.a = v.a;
    bus.b = v.b;
    bus.opcode = v.op;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk($sformatf("accept_timeout op%h", v.op), 32'(bus.in_ready), 32'd1);
    end else begin
      v.acc = cyc;
      sbq.push_back(v);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    // Scramble inputs after accept; a correct block has already captured them
    bus.a = ~v.a;
    bus.b = v.a ^ 16'h5A5A;
    bus.opcode = v.op ^ 4'h1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sbq.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on each output handshake
  initial begin
    int   rise;
    logic prev_ov;
    vec_t e;
    rise = 0;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (bus.out_valid && !prev_ov) rise = cyc;
        prev_ov = bus.out_valid;
        if (bus.out_valid && bus.out_ready) begin
          if (sbq.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            chk($sformatf("result op%h a=%h b=%h", e.op, e.a, e.b), 32'(bus.result), 32'(e.res));
            chk($sformatf("result_hi op%h a=%h b=%h", e.op, e.a, e.b), 32'(bus.result_hi), 32'(e.hi));
            chk($sformatf("flags(c,v,z,s,dz) op%h a=%h b=%h", e.op, e.a, e.b),
                32'({bus.carry, bus.overflow, bus.zero, bus.sign, bus.div_zero}),
                32'({e.c, e.v, e.z, e.s, e.dz}));
            chk($sformatf("latency op%h a=%h b=%h", e.op, e.a, e.b), 32'(rise - e.acc), 32'(e.lat));
          end
        end
      end
    end
  end

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.opcode = 4'h0;
    bus.out_ready = 1'b1;

    //            op     a        b        res      hi       c  v  z  s  dz lat
    tbl.push_back(mk(4'h0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 0, 1, 0, 1, 0, 1));
    tbl.push_back(mk(4'h1, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(4'hD, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1, 1, 0, 0, 0, 17));
    tbl.push_back(mk(4'hE, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 0, 0, 0, 0, 0, 17));
    tbl.push_back(mk(4'hE, 16'h00AB, 16'h0000, 16'hFFFF, 16'h00AB, 1, 0, 0, 1, 1, 1));
    tbl.push_back(mk(4'h0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(4'h1, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(4'h2, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'h3, 16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0000, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(4'h4, 16'hAAAA, 16'hFFFF, 16'h5555, 16'h0000, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'h5, 16'h00FF, 16'h1234, 16'hFF00, 16'h0000, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(4'h6, 16'h8001, 16'h0000, 16'h0002, 16'h0000, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'h7, 16'h0003, 16'h0000, 16'h0001, 16'h0000, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'h8, 16'h0003, 16'h0005, 16'h0001, 16'h0000, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'h9, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(4'hA, 16'h0005, 16'h0005, 16'h0001, 16'h0000, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'hB, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(4'hC, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(4'hD, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1, 1, 0, 0, 0, 17));
    tbl.push_back(mk(4'hD, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 0, 0, 0, 0, 0, 17));
    tbl.push_back(mk(4'hE, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 0, 0, 0, 0, 0, 17));
    tbl.push_back(mk(4'hF, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 1));

    repeat (3) @(negedge clk);
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset result", 32'(bus.result), 32'd0);
    chk("reset result_hi", 32'(bus.result_hi), 32'd0);
    chk("reset flags", 32'({bus.carry, bus.overflow, bus.zero, bus.sign, bus.div_zero}), 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) issue(tbl[i]);
    wait_drain();

    // Backpressure: result must hold and no second accept while DONE
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    issue(mk(4'h0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 0, 1, 0, 1, 0, 1));
    bus.a = 16'h00F0;
    bus.b = 16'h0F00;
    bus.opcode = 4'h3;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp in_ready c%0d", k), 32'(bus.in_ready), 32'd0);
      chk($sformatf("bp out_valid c%0d", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp result c%0d", k), 32'(bus.result), 32'h8000);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    issue(mk(4'h3, 16'h00F0, 16'h0F00, 16'h0FF0, 16'h0000, 0, 0, 0, 0, 0, 1));
    wait_drain();

    // Reset during the 5th MUL iteration
    issue(mk(4'hD, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1, 1, 0, 0, 0, 17));
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(sbq.pop_back());
    chk("mid-mul reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid-mul reset result", 32'(bus.result), 32'd0);
    chk("mid-mul reset result_hi", 32'(bus.result_hi), 32'd0);
    chk("mid-mul reset flags", 32'({bus.carry, bus.overflow, bus.zero, bus.sign, bus.div_zero}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("post-reset out_valid", 32'(bus.out_valid), 32'd0);
    issue(mk(4'h0, 16'h0001, 16'h0001, 16'h0002, 16'h0000, 0, 0, 0, 0, 0, 1));
    wait_drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
